// File: rtl/matrix_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : matrix_operand_loader
// Brief    : Walks the operand ROM, absorbs its read latency in a skid FIFO and
//            streams index/matrix-tagged words to the matrix core (valid/ready).
//            Optional operand-format check: define MATRIX_OPERAND_FP_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_operand_loader #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 3,
    parameter int N_ELEM  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_idx,
    output logic              m_sel,
    output logic              m_last,
    output logic              fp_err
);

    localparam int c_DEPTH = ROM_LAT + 1;
    localparam int c_PW    = (c_DEPTH > 2) ? $clog2(c_DEPTH) : 1;
    // One spare bit so fifo_count + inflight never wraps before the compare
    localparam int c_CW    = $clog2(c_DEPTH + 1) + 1;

    localparam logic [ADDR_W:0] c_NELEM   = (ADDR_W+1)'(N_ELEM);
    localparam logic [ADDR_W:0] c_HALF    = (ADDR_W+1)'(N_ELEM / 2);
    localparam logic [ADDR_W:0] c_LASTI   = (ADDR_W+1)'(N_ELEM - 1);
    localparam logic [c_CW-1:0] c_DEPTH_W = c_CW'(c_DEPTH);
    localparam logic [c_PW-1:0] c_PTR_MAX = c_PW'(c_DEPTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic [ADDR_W:0]    r_issue_ptr;
    logic [ADDR_W:0]    r_pop_cnt;
    logic [ROM_LAT-1:0] r_infl;
    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_PW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic               r_m_valid;
    logic [DATA_W-1:0]  r_m_data;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_CW-1:0]    w_infl_cnt;
    logic [c_CW-1:0]    w_occ;
    logic [c_CW-1:0]    w_count_left;
    logic [c_CW-1:0]    w_count_nxt;
    logic [c_PW-1:0]    w_wr_adv;
    logic [c_PW-1:0]    w_rd_adv;
    logic [c_PW-1:0]    w_rd_nxt;
    logic [DATA_W-1:0]  w_head_nxt;

    function automatic logic [c_PW-1:0] f_wrap_inc(input logic [c_PW-1:0] p);
        return (p == c_PTR_MAX) ? '0 : p + c_PW'(1);
    endfunction

    always_comb begin
        w_infl_cnt = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            w_infl_cnt = w_infl_cnt + c_CW'(r_infl[i]);
        end
    end

    assign w_pop        = r_m_valid & m_ready;
    assign w_push       = r_infl[ROM_LAT-1];
    assign w_occ        = r_count + w_infl_cnt - c_CW'(w_pop);
    assign w_issue      = (r_state == c_RUN) && (r_issue_ptr < c_NELEM) && (w_occ < c_DEPTH_W);
    assign w_count_left = r_count - c_CW'(w_pop);
    assign w_count_nxt  = w_count_left + c_CW'(w_push);
    assign w_wr_adv     = f_wrap_inc(r_wr_ptr);
    assign w_rd_adv     = f_wrap_inc(r_rd_ptr);
    assign w_rd_nxt     = w_pop ? w_rd_adv : r_rd_ptr;

    // The output register mirrors the FIFO head; an empty FIFO bypasses rom_data
    assign w_head_nxt   = (w_count_left == '0) ? rom_data : r_mem[w_rd_nxt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_issue_ptr <= '0;
            r_pop_cnt   <= '0;
            r_infl      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        r_state     <= c_RUN;
                        r_busy      <= 1'b1;
                        r_issue_ptr <= '0;
                        r_pop_cnt   <= '0;
                        r_infl      <= '0;
                        r_wr_ptr    <= '0;
                        r_rd_ptr    <= '0;
                        r_count     <= '0;
                        r_m_valid   <= 1'b0;
                    end
                end
                c_RUN: begin
                    if (w_issue) begin
                        r_issue_ptr <= r_issue_ptr + 1'b1;
                    end
                    r_infl <= (r_infl << 1) | ROM_LAT'(w_issue);
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= rom_data;
                        r_wr_ptr        <= w_wr_adv;
                    end
                    if (w_pop) begin
                        r_rd_ptr  <= w_rd_adv;
                        r_pop_cnt <= r_pop_cnt + 1'b1;
                    end
                    r_count   <= w_count_nxt;
                    r_m_valid <= (w_count_nxt != '0);
                    if (w_count_nxt != '0) begin
                        r_m_data <= w_head_nxt;
                    end
                    if (w_pop && (r_pop_cnt == c_LASTI)) begin
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rom_addr = (r_state == c_RUN) ? r_issue_ptr[ADDR_W-1:0] : '0;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_idx    = r_pop_cnt[ADDR_W-1:0];
    assign m_sel    = (r_pop_cnt >= c_HALF);
    assign m_last   = (r_pop_cnt == c_LASTI);

`ifdef MATRIX_OPERAND_FP_CHECK_EN
    logic r_fp_err;
    logic w_fp_bad;

    // IEEE-754 single: Inf/NaN (exponent all ones) or denormal (zero exponent, non-zero mantissa)
    assign w_fp_bad = (r_m_data[30:23] == 8'hFF) ||
                      ((r_m_data[30:23] == 8'h00) && (r_m_data[22:0] != 23'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fp_err <= 1'b0;
        end else if ((r_state == c_IDLE) && start) begin
            r_fp_err <= 1'b0;
        end else if (w_pop && w_fp_bad) begin
            r_fp_err <= 1'b1;
        end
    end

    assign fp_err = r_fp_err;
`else
    assign fp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_operand_loader
// Brief    : Self-checking bench: timing table, backpressure, random ready,
//            start-while-busy, mid-load reset and operand-format check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_operand_loader;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 3;
    localparam int N_ELEM  = 8;
    localparam int ROM_LAT = 1;
    localparam int N_TBL   = 12;
`ifdef MATRIX_OPERAND_FP_CHECK_EN
    localparam bit c_FP_EN = 1'b1;
`else
    localparam bit c_FP_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_idx;
    logic              m_sel;
    logic              m_last;
    logic              fp_err;

    logic [DATA_W-1:0] rom_mem [N_ELEM];

    typedef struct {
        logic              start;
        logic              ready;
        logic              busy;
        logic              done;
        logic              valid;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } vec_t;

    vec_t tbl [N_TBL];

    int errors;
    int checks;
    int exp_idx;
    int dones;

    matrix_operand_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_ELEM (N_ELEM),
        .ROM_LAT(ROM_LAT)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_idx   (m_idx),
        .m_sel   (m_sel),
        .m_last  (m_last),
        .fp_err  (fp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read ROM, one cycle of latency
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: score the handshake about to happen, advance, then check holds and done
    task automatic step();
        logic              hs;
        logic              hold;
        logic              exp_done;
        logic [DATA_W-1:0] hd;
        logic [ADDR_W-1:0] hi;
        logic              hsel;
        logic              hlast;
        hs       = m_valid && m_ready && !rst;
        hold     = m_valid && !m_ready && !rst;
        hd       = m_data;
        hi       = m_idx;
        hsel     = m_sel;
        hlast    = m_last;
        exp_done = 1'b0;
        if (hs) begin
            if (exp_idx >= N_ELEM) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got idx %0d data %0h expected no beat", m_idx, m_data);
            end else begin
                chk("beat_data", m_data, rom_mem[exp_idx]);
                chk("beat_idx", m_idx, exp_idx);
                chk("beat_sel", m_sel, exp_idx >= N_ELEM / 2);
                chk("beat_last", m_last, exp_idx == N_ELEM - 1);
                exp_done = (exp_idx == N_ELEM - 1);
                exp_idx++;
            end
        end
        @(posedge clk);
        #1;
        if (hold && !rst) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, hd);
            chk("hold_idx", m_idx, hi);
            chk("hold_sel", m_sel, hsel);
            chk("hold_last", m_last, hlast);
        end
        if (!rst) chk("done", done, exp_done);
        if (done) dones++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_valid"}, m_valid, 1'b0);
        chk({tag, "_data"}, m_data, 32'h0);
        chk({tag, "_idx"}, m_idx, 3'd0);
        chk({tag, "_sel"}, m_sel, 1'b0);
        chk({tag, "_last"}, m_last, 1'b0);
        chk({tag, "_addr"}, rom_addr, 3'd0);
        chk({tag, "_fperr"}, fp_err, 1'b0);
    endtask

    task automatic begin_load(input bit rnd);
        exp_idx = 0;
        dones   = 0;
        start   = 1'b1;
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        start   = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input bit rnd, input bit poke);
        int cyc;
        cyc = 0;
        while (dones == 0 && cyc < 300) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start   = poke && (cyc == 4);
            step();
            cyc++;
        end
        start = 1'b0;
        chk("load_timeout", cyc < 300, 1'b1);
        chk("beat_count", exp_idx, N_ELEM);
        chk("done_count", dones, 1);
    endtask

    // Leaves DONE (optionally with a start that must be ignored) and confirms IDLE
    task automatic finish_load(input bit poke);
        start = poke;
        step();
        start = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", m_valid, 1'b0);
    endtask

    task automatic run_load(input bit rnd, input bit poke);
        begin_load(rnd);
        wait_done(rnd, poke);
        finish_load(poke);
    endtask

    initial begin
        int  cyc;
        bit  found;
        errors  = 0;
        checks  = 0;
        exp_idx = N_ELEM;
        dones   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;

        rom_mem[0] = 32'h41633404;
        rom_mem[1] = 32'h3F800000;
        rom_mem[2] = 32'h40490FDB;
        rom_mem[3] = 32'h429678A0;
        rom_mem[4] = 32'hC0200000;
        rom_mem[5] = 32'h3E99999A;
        rom_mem[6] = 32'h42C80000;
        rom_mem[7] = 32'h41EEC4D0;

        // Nominal timing: start taken at E0, beat k shown after E(k+2), done after E10
        for (int k = 0; k < N_TBL; k++) begin
            tbl[k].start = (k == 0);
            tbl[k].ready = 1'b1;
            tbl[k].busy  = (k <= 10);
            tbl[k].done  = (k == 10);
            tbl[k].valid = (k >= 2) && (k <= 9);
            tbl[k].idx   = '0;
            tbl[k].data  = '0;
            if (k >= 2 && k <= 9) begin
                tbl[k].idx  = ADDR_W'(k - 2);
                tbl[k].data = rom_mem[k - 2];
            end
        end

        repeat (3) step();
        check_reset("rst");
        rst = 1'b0;
        step();

        // Table-driven nominal stream
        exp_idx = 0;
        dones   = 0;
        for (int k = 0; k < N_TBL; k++) begin
            start   = tbl[k].start;
            m_ready = tbl[k].ready;
            step();
            chk("tbl_busy", busy, tbl[k].busy);
            chk("tbl_done", done, tbl[k].done);
            chk("tbl_valid", m_valid, tbl[k].valid);
            if (tbl[k].valid) begin
                chk("tbl_idx", m_idx, tbl[k].idx);
                chk("tbl_data", m_data, tbl[k].data);
                chk("tbl_sel", m_sel, tbl[k].idx >= ADDR_W'(N_ELEM / 2));
                chk("tbl_last", m_last, tbl[k].idx == ADDR_W'(N_ELEM - 1));
            end
        end
        start = 1'b0;
        chk("tbl_beats", exp_idx, N_ELEM);

        // Backpressure on beat 3
        begin_load(1'b0);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 20) begin
            if (m_valid && m_idx == 3'd3) found = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        chk("bp_reach", found, 1'b1);
        m_ready = 1'b0;
        repeat (5) begin
            step();
            chk("bp_data", m_data, 32'h429678A0);
            chk("bp_idx", m_idx, 3'd3);
        end
        wait_done(1'b0, 1'b0);
        finish_load(1'b0);

        // Random ready over 20 loads
        for (int n = 0; n < 20; n++) run_load(1'b1, 1'b0);

        // Start mid-load and during DONE ignored; next start one cycle after DONE
        run_load(1'b0, 1'b1);
        run_load(1'b1, 1'b1);
        run_load(1'b0, 1'b0);

        // Reset after beat 4 accepted
        begin_load(1'b0);
        cyc = 0;
        while (exp_idx < 5 && cyc < 30) begin
            step();
            cyc++;
        end
        chk("mr_reach", exp_idx, 5);
        m_ready = 1'b0;
        rst     = 1'b1;
        step();
        check_reset("midrst");
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (4) begin
            step();
            chk("no_stale", m_valid, 1'b0);
        end
        run_load(1'b0, 1'b0);

        // Operand-format check: word 5 is +Inf
        rom_mem[5] = 32'h7F800000;
        begin_load(1'b0);
        cyc = 0;
        while (dones == 0 && cyc < 50) begin
            m_ready = 1'b1;
            step();
            cyc++;
            chk("fp_err", fp_err, c_FP_EN && (exp_idx > 5));
        end
        chk("fp_timeout", cyc < 50, 1'b1);
        finish_load(1'b0);
        chk("fp_sticky", fp_err, c_FP_EN);
        rom_mem[5] = 32'h3E99999A;
        begin_load(1'b0);
        chk("fp_clear", fp_err, 1'b0);
        wait_done(1'b0, 1'b0);
        finish_load(1'b0);
        chk("fp_stay_clear", fp_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Downstream consumer of the 8-entry IEEE-754 single-precision operand ROM, which has 1-cycle registered read latency.
- On `start`, walks ROM addresses 0..N_ELEM-1 and absorbs the read latency through a small skid FIFO.
- Streams each word to the matrix multiplier core over a valid/ready interface.
- Tags each word with its element index and its operand matrix: A = first half, B = second half.

Parameters:
- DATA_W, 32, operand word width (IEEE-754 single).
- ADDR_W, 3, ROM address width.
- N_ELEM, 8, words per load. Must be even and ≤ 2^ADDR_W.
- ROM_LAT, 1, ROM read latency in cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  load request. Sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until the DONE state ends.
- done  output  1  one-cycle pulse after the last beat is accepted.
- rom_addr  output  ADDR_W  address to the ROM.
- rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after the address is issued.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream ready.
- m_data  output  DATA_W  operand word.
- m_idx  output  ADDR_W  element index of the current beat.
- m_sel  output  1  0 = matrix A (m_idx < N_ELEM/2), 1 = matrix B.
- m_last  output  1  high on the beat with m_idx = N_ELEM-1.
- fp_err  output  1  sticky operand-format error (optional feature only).

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst` is synchronous, active-high. It overrides everything, including mid-load.
  - Reset values: busy=0, done=0, m_valid=0, m_data=0, m_idx=0, m_sel=0, m_last=0, rom_addr=0, fp_err=0. State = IDLE, all pointers 0.
  - In-flight ROM reads are discarded on reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, rom_addr=0. start=1 moves to RUN and clears issue_ptr, pop_cnt and the FIFO.
  - RUN:
    - Issue condition: issue_ptr < N_ELEM and (fifo_count + inflight − pop) < ROM_LAT+1, where pop = m_valid & m_ready this cycle.
    - When the condition holds, drive rom_addr = issue_ptr and increment issue_ptr.
    - A ROM_LAT-deep shift register tracks in-flight reads. When a read matures, rom_data is written into the FIFO (depth ROM_LAT+1 = 2) at the end of that cycle.
    - Push and pop in the same cycle are both honoured. The FIFO never overflows.
    - RUN exits to DONE on the handshake with m_last=1.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Output interface:
  - m_valid = FIFO non-empty. m_data = FIFO head.
  - m_idx = pop_cnt. m_sel = (pop_cnt ≥ N_ELEM/2). m_last = (pop_cnt == N_ELEM−1).
  - While m_valid & !m_ready, m_data, m_idx, m_sel and m_last hold stable.
  - No beat is dropped or duplicated.
- Timing:
  - Throughput is 1 beat/cycle with m_ready held high.
  - With start sampled at edge E0: first read issues in cycle after E0, data is captured at E2, m_valid is high after E2.
  - The eighth beat is presented in the cycle after E9; done is high in the cycle after E10.
- Arithmetic: pointers are ADDR_W+1 bits wide, so N_ELEM = 2^ADDR_W does not wrap. rom_addr uses the low ADDR_W bits.
- When m_valid=0, m_data holds its last value; it is not cleared.

Optional Feature:
- Macro: MATRIX_OPERAND_FP_CHECK_EN.
- Defined:
  - Each accepted beat is checked.
  - Error condition: exponent == 8'hFF (Inf/NaN), or exponent == 0 with mantissa ≠ 0 (denormal).
  - On a match, fp_err sets in the cycle after that handshake.
  - fp_err is sticky until start is accepted or rst.
  - Data is still forwarded unchanged.
- Undefined: fp_err is tied to 0 and no check logic is built.

Test Plan:
- Nominal stream: ROM model with production contents, m_ready=1, pulse start.
  - Required: 8 consecutive beats with m_idx 0..7.
  - First beat m_data=0x41633404, m_sel=0. Beat 3 = 0x429678A0.
  - Beat 7 = 0x41EEC4D0 with m_last=1, m_sel=1.
  - done pulses exactly once, the cycle after the last handshake. busy then falls.
- Backpressure: drop m_ready for 5 cycles while beat 3 is presented.
  - Required: m_data holds 0x429678A0 and m_idx holds 3 throughout.
  - Never more than 2 words buffered or in flight.
  - Beats 4..7 follow in order with no duplicates.
- Random m_ready (50% toggling) over 20 loads.
  - Required: every load delivers exactly 0..7 in order, m_sel transitions at idx 4, one done per load.
- Start while busy: pulse start mid-load and again during DONE.
  - Required: both ignored, single 8-beat sequence.
  - A start one cycle after DONE begins a fresh load from idx 0.
- Reset mid-load: assert rst after beat 4 is accepted.
  - Required: next cycle all outputs at reset values and no stale beats appear.
  - A subsequent start yields a full 8 beats from 0x41633404.
- FP check: ROM model word 5 = 0x7F800000, macro defined.
  - Required: fp_err=1 from the cycle after beat 5 is accepted, held through done, cleared on next start.
  - With the macro undefined, fp_err stays 0.
